// File: rtl/result_display_if.sv
// Handshake and display bundle between the KNN result source and the display stage.
interface result_display_if;
    logic        done;
    logic        predicted_class;
    logic        K_mode;
    logic [15:0] latency;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        class_led;
    logic        result_valid;
    logic        busy;

    modport master (
        output done, predicted_class, K_mode, latency,
        input  seg, dp, an, class_led, result_valid, busy
    );

    modport slave (
        input  done, predicted_class, K_mode, latency,
        output seg, dp, an, class_led, result_valid, busy
    );
endinterface

// File: rtl/result_display.sv
// KNN result display: captures a finished result, converts latency to BCD with a
// sequential double-dabble and scans it onto a 4-digit multiplexed 7-segment display.
module result_display #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    result_display_if.slave  bus
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Internal encoding is active-low; these masks flip it for active-high boards.
    localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
    localparam logic [3:0] AN_INV  = SEG_ACTIVE_LOW ? 4'h0  : 4'hF;
    localparam logic       DP_INV  = SEG_ACTIVE_LOW ? 1'b0  : 1'b1;

    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // One double-dabble step on {bcd[15:0], binary[13:0]}: adjust nibbles, then shift.
    function automatic logic [29:0] dd_step(input logic [29:0] sh);
        logic [29:0] t;
        t = sh;
        for (int i = 0; i < 4; i++) begin
            if (t[14 + 4*i +: 4] >= 4'd5) begin
                t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
            end else begin
                t[14 + 4*i +: 4] = t[14 + 4*i +: 4];
            end
        end
        return {t[28:0], 1'b0};
    endfunction

    state_t             state_r;
    logic [29:0]        shift_r;
    logic [3:0]         iter_r;
    logic               cls_cap_r;
    logic               k_cap_r;
    logic               sat_cap_r;
    logic               busy_r;
    logic [15:0]        digits_r;
    logic               class_led_r;
    logic               k_disp_r;
    logic               sat_disp_r;
    logic               result_valid_r;
    logic [CNT_W-1:0]   refresh_cnt_r;
    logic [1:0]         digit_idx_r;
    logic [6:0]         seg_r;
    logic [3:0]         an_r;
    logic               dp_r;

    logic               sat_s;
    logic [13:0]        lat_sat_s;
    logic [3:0]         cur_digit_s;
    logic               blank_s;
    logic               dp_on_s;
    logic [6:0]         seg_int_s;
    logic               dp_int_s;
    logic [3:0]         an_int_s;

    assign sat_s     = (bus.latency > 16'd9999);
    assign lat_sat_s = sat_s ? 14'd9999 : bus.latency[13:0];

    // Capture / convert / commit sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            shift_r        <= 30'd0;
            iter_r         <= 4'd0;
            cls_cap_r      <= 1'b0;
            k_cap_r        <= 1'b0;
            sat_cap_r      <= 1'b0;
            busy_r         <= 1'b0;
            digits_r       <= 16'd0;
            class_led_r    <= 1'b0;
            k_disp_r       <= 1'b0;
            sat_disp_r     <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.done) begin
                        shift_r   <= {16'd0, lat_sat_s};
                        cls_cap_r <= bus.predicted_class;
                        k_cap_r   <= bus.K_mode;
                        sat_cap_r <= sat_s;
                        iter_r    <= 4'd0;
                        busy_r    <= 1'b1;
                        state_r   <= CONV;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                CONV: begin
                    shift_r <= dd_step(shift_r);
                    iter_r  <= iter_r + 4'd1;
                    if (iter_r == 4'd13) begin
                        state_r <= COMMIT;
                    end else begin
                        state_r <= CONV;
                    end
                end
                COMMIT: begin
                    digits_r       <= shift_r[29:14];
                    class_led_r    <= cls_cap_r;
                    k_disp_r       <= k_cap_r;
                    sat_disp_r     <= sat_cap_r;
                    result_valid_r <= 1'b1;
                    busy_r         <= 1'b0;
                    state_r        <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Digit refresh timer and scan index.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt_r <= '0;
            digit_idx_r   <= 2'd0;
        end else if (refresh_cnt_r == CNT_LAST) begin
            refresh_cnt_r <= '0;
            digit_idx_r   <= digit_idx_r + 2'd1;
        end else begin
            refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
        end
    end

    // Select the active digit and derive its segments, dp and anode (active-low form).
    always_comb begin
        cur_digit_s = 4'd0;
        blank_s     = 1'b0;
        dp_on_s     = 1'b0;
        case (digit_idx_r)
            2'd0: begin
                cur_digit_s = digits_r[3:0];
                dp_on_s     = k_disp_r;
            end
            2'd1: begin
                cur_digit_s = digits_r[7:4];
                blank_s     = (digits_r[15:4] == 12'd0);
            end
            2'd2: begin
                cur_digit_s = digits_r[11:8];
                blank_s     = (digits_r[15:8] == 8'd0);
            end
            2'd3: begin
                cur_digit_s = digits_r[15:12];
                blank_s     = (digits_r[15:12] == 4'd0);
                dp_on_s     = sat_disp_r;
            end
            default: begin
                cur_digit_s = 4'd0;
                blank_s     = 1'b1;
                dp_on_s     = 1'b0;
            end
        endcase

        an_int_s = ~(4'b0001 << digit_idx_r);
        if (!result_valid_r) begin
            seg_int_s = SEG_DASH;
            dp_int_s  = 1'b1;
        end else begin
            seg_int_s = blank_s ? SEG_BLANK : seg_code(cur_digit_s);
            dp_int_s  = ~dp_on_s;
        end
    end

    // Register seg/an/dp together so anode and segment data switch on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_r <= SEG_BLANK ^ SEG_INV;
            an_r  <= 4'hF ^ AN_INV;
            dp_r  <= 1'b1 ^ DP_INV;
        end else begin
            seg_r <= seg_int_s ^ SEG_INV;
            an_r  <= an_int_s ^ AN_INV;
            dp_r  <= dp_int_s ^ DP_INV;
        end
    end

    assign bus.seg          = seg_r;
    assign bus.an           = an_r;
    assign bus.dp           = dp_r;
    assign bus.class_led    = class_led_r;
    assign bus.result_valid = result_valid_r;
    assign bus.busy         = busy_r;
endmodule

// File: tb/tb_result_display.sv
// Scoreboard bench for result_display: stimulus pushes expected results, a monitor
// checks each commit and the scanned display against a decimal reference model.
module tb_result_display;
    typedef struct {
        int lat;
        bit cls;
        bit k;
    } exp_t;

    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [3:0] AN_SEQ [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    result_display_if bus ();

    result_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: digit k of the saturated decimal value, with blanking and dp rules.
    function automatic int exp_seg(input exp_t e, input int k);
        int v;
        int p;
        v = (e.lat > 9999) ? 9999 : e.lat;
        p = 10 ** k;
        if (k > 0 && v < p) return 32'h7F;
        return int'(SEG_TAB[(v / p) % 10]);
    endfunction

    function automatic int exp_dp(input exp_t e, input int k);
        if (k == 0 && e.k) return 0;
        if (k == 3 && e.lat > 9999) return 0;
        return 1;
    endfunction

    task automatic check_commit(input int busy_cnt);
        exp_t e;
        logic [6:0] seg_seen [4];
        logic       dp_seen [4];
        bit         seen [4];
        if (exp_q.size() == 0) begin
            chk("unexpected_commit", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk("busy_len", busy_cnt, 15);
        chk("result_valid", int'(bus.result_valid), 1);
        chk("class_led", int'(bus.class_led), int'(e.cls));
        for (int k = 0; k < 4; k++) seen[k] = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (bus.an == AN_SEQ[k]) begin
                    seen[k]     = 1'b1;
                    seg_seen[k] = bus.seg;
                    dp_seen[k]  = bus.dp;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("digit%0d_seen", k), int'(seen[k]), 1);
            if (seen[k]) begin
                chk($sformatf("lat%0d_digit%0d_seg", e.lat, k), int'(seg_seen[k]), exp_seg(e, k));
                chk($sformatf("lat%0d_digit%0d_dp", e.lat, k), int'(dp_seen[k]), exp_dp(e, k));
            end
        end
    endtask

    // Monitor: a falling busy without reset is a commit to be scored.
    initial begin : monitor
        int   busy_cnt;
        logic prev_busy;
        busy_cnt  = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (prev_busy && !bus.busy) begin
                if (!reset) check_commit(busy_cnt);
                busy_cnt = 0;
            end
            prev_busy = bus.busy;
        end
    end

    task automatic pulse(input int lat, input bit cls, input bit k, input bit expect_commit);
        exp_t e;
        @(posedge clk);
        #2;
        bus.done            = 1'b1;
        bus.latency         = 16'(lat);
        bus.predicted_class = cls;
        bus.K_mode          = k;
        if (expect_commit) begin
            e.lat = lat;
            e.cls = cls;
            e.k   = k;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #2;
        bus.done            = 1'b0;
        bus.latency         = 16'($urandom);
        bus.predicted_class = 1'($urandom);
        bus.K_mode          = 1'($urandom);
    endtask

    task automatic check_reset_and_dashes();
        @(negedge clk);
        chk("rst_seg", int'(bus.seg), 32'h7F);
        chk("rst_an", int'(bus.an), 32'hF);
        chk("rst_dp", int'(bus.dp), 1);
        chk("rst_result_valid", int'(bus.result_valid), 0);
        chk("rst_class_led", int'(bus.class_led), 0);
        chk("rst_busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            chk("dash_seg", int'(bus.seg), 32'h3F);
            chk("dash_dp", int'(bus.dp), 1);
            @(negedge clk);
        end
    endtask

    task automatic check_an_sequence();
        logic [3:0] prev_an;
        bit         found;
        found   = 1'b0;
        prev_an = bus.an;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (bus.an == 4'hE && prev_an != 4'hE) found = 1'b1;
            prev_an = bus.an;
        end
        chk("an_sync_found", int'(found), 1);
        if (found) begin
            for (int j = 0; j < 17; j++) begin
                chk($sformatf("an_seq%0d", j), int'(bus.an), int'(AN_SEQ[(j / 4) % 4]));
                @(negedge clk);
            end
        end
    endtask

    initial begin : stimulus
        int lat;
        checks              = 0;
        failures            = 0;
        reset               = 1'b1;
        bus.done            = 1'b0;
        bus.predicted_class = 1'b0;
        bus.K_mode          = 1'b0;
        bus.latency         = 16'd0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        check_reset_and_dashes();

        pulse(37, 1'b1, 1'b0, 1'b1);
        repeat (50) @(posedge clk);

        pulse(12000, 1'b0, 1'b0, 1'b1);
        repeat (50) @(posedge clk);

        // Second done arrives at N+5 while converting and must be dropped.
        pulse(250, 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        pulse(8, 1'b1, 1'b0, 1'b0);
        repeat (50) @(posedge clk);
        chk("no_second_conv_busy", int'(bus.busy), 0);

        // Reset at N+7 aborts the conversion and discards the previous result.
        pulse(500, 1'b1, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        check_reset_and_dashes();

        pulse(0, 1'b0, 1'b1, 1'b1);
        repeat (50) @(posedge clk);
        check_an_sequence();

        for (int r = 0; r < 10; r++) begin
            case ($urandom_range(0, 3))
                0:       lat = int'($urandom_range(0, 99));
                1:       lat = int'($urandom_range(0, 9999));
                2:       lat = int'($urandom_range(10000, 65535));
                default: lat = 9999 + int'($urandom_range(0, 1));
            endcase
            pulse(lat, 1'($urandom), 1'($urandom), 1'b1);
            repeat (50) @(posedge clk);
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
